// File: rtl/axi4_bram_responder.sv
// AXI4 responder in front of a single-port, byte-writable 32-bit word memory.
// It serves one INCR burst at a time, either a read or a write. It has no ID or RESP
// signalling, so every response is OKAY.
module axi4_bram_responder #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic                  s_axi_rlast,
    output logic                  protocol_err
);

    localparam int unsigned     IdxW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axi4_bram_responder: DATA_WIDTH must be 32");
    end
    if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axi4_bram_responder: MEM_DEPTH must be a power of 2");
    end

    typedef enum logic [2:0] {StIdle, StWData, StWResp, StRRead, StRData} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      beats_q, beats_d;
    logic            grant_wr_q, grant_wr_d;  // 1: write wins the next conflict
    logic [31:0]     rdata_q, rdata_d;
    logic            perr_q, perr_d;
    logic            grant_wr;
    logic            wr_beat;

    logic [31:0]     mem_q [MEM_DEPTH];

    // Subtracting the base before taking the index makes the index wrap modulo MEM_DEPTH.
    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic [IdxW-1:0]       aw_idx, ar_idx;
    logic                  unused_addr_bits;

    assign aw_off = s_axi_awaddr - BASE_ADDR;
    assign ar_off = s_axi_araddr - BASE_ADDR;
    assign aw_idx = aw_off[IdxW+1:2];
    assign ar_idx = ar_off[IdxW+1:2];
    assign unused_addr_bits = ^{aw_off[ADDR_WIDTH-1:IdxW+2], aw_off[1:0],
                                ar_off[ADDR_WIDTH-1:IdxW+2], ar_off[1:0]};

    // A lone requester always wins. When both request, the pointer picks the winner.
    assign grant_wr = s_axi_awvalid & (~s_axi_arvalid | grant_wr_q);

    assign s_axi_rdata  = rdata_q;
    assign protocol_err = perr_q;

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        beats_d       = beats_q;
        grant_wr_d    = grant_wr_q;
        rdata_d       = rdata_q;
        perr_d        = perr_q;
        wr_beat       = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_axi_awready = s_axi_awvalid & grant_wr;
                s_axi_arready = s_axi_arvalid & ~grant_wr;
                if (s_axi_awready) begin
                    idx_d      = aw_idx;
                    beats_d    = s_axi_awlen;
                    grant_wr_d = 1'b0;
                    state_d    = StWData;
                end else if (s_axi_arready) begin
                    idx_d      = ar_idx;
                    beats_d    = s_axi_arlen;
                    grant_wr_d = 1'b1;
                    state_d    = StRRead;
                end
            end
            StWData: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    wr_beat = 1'b1;
                    idx_d   = idx_q + IdxOne;
                    // The beat count ends the burst. A misplaced wlast is only flagged.
                    if (s_axi_wlast != (beats_q == 8'd0)) begin
                        perr_d = 1'b1;
                    end
                    if (beats_q == 8'd0) begin
                        state_d = StWResp;
                    end else begin
                        beats_d = beats_q - 8'd1;
                    end
                end
            end
            StWResp: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_d = StIdle;
                end
            end
            StRRead: begin
                rdata_d = mem_q[idx_q];
                state_d = StRData;
            end
            StRData: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = (beats_q == 8'd0);
                if (s_axi_rready) begin
                    if (s_axi_rlast) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + IdxOne;
                        beats_d = beats_q - 8'd1;
                        state_d = StRRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and read-data registers with asynchronous reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            beats_q    <= '0;
            grant_wr_q <= 1'b1;
            rdata_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            beats_q    <= beats_d;
            grant_wr_q <= grant_wr_d;
            rdata_q    <= rdata_d;
            perr_q     <= perr_d;
        end
    end

    // Byte-lane memory write. Memory contents are not reset.
    always_ff @(posedge ap_clk) begin
        if (wr_beat) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_bram_responder.sv
// Randomized self-checking bench for axi4_bram_responder, checked against a word-array model.
module tb_axi4_bram_responder;

    localparam int unsigned Depth = 4096;
    localparam logic [63:0] Base  = 64'h0000_0000_8000_0000;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic        s_axi_arvalid, s_axi_arready;
    logic [63:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rlast;
    logic        protocol_err;

    axi4_bram_responder #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(32),
        .MEM_DEPTH (Depth),
        .BASE_ADDR (Base)
    ) u_dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awlen  (s_axi_awlen),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wlast  (s_axi_wlast),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arlen  (s_axi_arlen),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rlast  (s_axi_rlast),
        .protocol_err (protocol_err)
    );

    always #5 ap_clk = ~ap_clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: word memory, arbitration preference, sticky error flag.
    logic [31:0] mdl [Depth];
    bit          pref_wr;
    bit          perr_m;
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [63:0] a);
        logic [63:0] t;
        t = (a - Base) >> 2;
        return int'(t % 64'(Depth));
    endfunction

    // All phase tasks start and end 1 time unit after a rising edge.
    task automatic aw_phase(input logic [63:0] addr, input int len);
        int n;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awvalid = 1'b1;
        n = 0;
        @(negedge ap_clk);
        while (!s_axi_awready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check("aw_grant", 64'(s_axi_awready), 64'd1);
        check("aw_excl", 64'(s_axi_arready), 64'd0);
        @(posedge ap_clk);
        #1 s_axi_awvalid = 1'b0;
        pref_wr = 1'b0;
    endtask

    task automatic w_phase(input logic [63:0] addr, input int len, input int bad);
        int n;
        int idx;
        idx = widx(addr);
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                @(posedge ap_clk);
                #1;
            end
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wd[b];
            s_axi_wstrb  = ws[b];
            s_axi_wlast  = (bad >= 0) ? (b == bad) : (b == len);
            if (s_axi_wlast != (b == len)) perr_m = 1'b1;
            n = 0;
            @(negedge ap_clk);
            while (!s_axi_wready && n < 50) begin
                @(negedge ap_clk);
                n++;
            end
            check("w_ready", 64'(s_axi_wready), 64'd1);
            @(posedge ap_clk);
            for (int k = 0; k < 4; k++) begin
                if (ws[b][k]) mdl[idx][8*k +: 8] = wd[b][8*k +: 8];
            end
            idx = (idx + 1) % Depth;
            #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    // Optionally raises the next AW request together with bready to create a fresh conflict.
    task automatic b_phase(input bit next_aw, input logic [63:0] next_addr, input int next_len);
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!s_axi_bvalid && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check("b_valid", 64'(s_axi_bvalid), 64'd1);
        check("b_perr", 64'(protocol_err), 64'(perr_m));
        repeat ($urandom_range(0, 2)) begin
            @(negedge ap_clk);
            check("b_hold", 64'(s_axi_bvalid), 64'd1);
        end
        if (next_aw) begin
            s_axi_awaddr  = next_addr;
            s_axi_awlen   = 8'(next_len);
            s_axi_awvalid = 1'b1;
            #1 check("b_no_aw", 64'(s_axi_awready), 64'd0);
        end
        s_axi_bready = 1'b1;
        @(posedge ap_clk);
        #1 s_axi_bready = 1'b0;
        check("b_once", 64'(s_axi_bvalid), 64'd0);
    endtask

    task automatic ar_phase(input logic [63:0] addr, input int len);
        int n;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge ap_clk);
        while (!s_axi_arready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check("ar_grant", 64'(s_axi_arready), 64'd1);
        check("ar_excl", 64'(s_axi_awready), 64'd0);
        @(posedge ap_clk);
        #1 s_axi_arvalid = 1'b0;
        pref_wr = 1'b1;
    endtask

    // mode 0: random rready; mode 1: rready 1,0,0,1 on valid cycles, then 1.
    task automatic r_phase(input logic [63:0] addr, input int len, input int mode);
        int  beat, cyc, pi, idx0;
        bit  first;
        bit  pat [4];
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        beat  = 0;
        cyc   = 0;
        pi    = 0;
        first = 1'b1;
        idx0  = widx(addr);
        while (beat <= len && cyc < 300) begin
            if (s_axi_rvalid) begin
                if (mode == 1) begin
                    s_axi_rready = (pi < 4) ? pat[pi] : 1'b1;
                    pi++;
                end else begin
                    s_axi_rready = 1'($urandom_range(0, 1));
                end
            end else begin
                s_axi_rready = 1'($urandom_range(0, 1));
            end
            @(negedge ap_clk);
            cyc++;
            if (s_axi_rvalid) begin
                if (first) begin
                    check("r_latency", 64'(cyc), 64'd2);
                    first = 1'b0;
                end
                check("r_data", 64'(s_axi_rdata), 64'(mdl[(idx0 + beat) % Depth]));
                check("r_last", 64'(s_axi_rlast), 64'(beat == len));
                if (s_axi_rready) beat++;
            end
            @(posedge ap_clk);
            #1;
        end
        s_axi_rready = 1'b0;
        check("r_beats", 64'(beat), 64'(len + 1));
        check("r_idle", 64'(s_axi_rvalid), 64'd0);
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input int bad);
        aw_phase(addr, len);
        w_phase(addr, len, bad);
        b_phase(1'b0, 64'd0, 0);
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input int mode);
        ar_phase(addr, len);
        r_phase(addr, len, mode);
    endtask

    initial begin
        int n;
        ap_rst_n      = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_rready  = 1'b0;
        pref_wr       = 1'b1;
        perr_m        = 1'b0;

        // Reset state.
        repeat (2) @(negedge ap_clk);
        check("rst_awready", 64'(s_axi_awready), 64'd0);
        check("rst_arready", 64'(s_axi_arready), 64'd0);
        check("rst_wready", 64'(s_axi_wready), 64'd0);
        check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rst_rlast", 64'(s_axi_rlast), 64'd0);
        check("rst_rdata", 64'(s_axi_rdata), 64'd0);
        check("rst_perr", 64'(protocol_err), 64'd0);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // Single-beat write and readback.
        wd[0] = 32'hDEAD_BEEF;
        ws[0] = 4'hF;
        do_write(Base + 64'h10, 0, -1);
        do_read(Base + 64'h10, 0, 0);

        // Partial-strobe burst over a prefilled region.
        for (int b = 0; b < 4; b++) begin
            wd[b] = 32'hFFFF_FFFF;
            ws[b] = 4'hF;
        end
        do_write(Base + 64'h100, 3, -1);
        for (int b = 0; b < 4; b++) begin
            wd[b] = 32'(b + 1);
            ws[b] = (b == 2) ? 4'h3 : 4'hF;
        end
        do_write(Base + 64'h100, 3, -1);
        check("strb_word", 64'(mdl[widx(Base + 64'h108)]), 64'hFFFF_0003);
        do_read(Base + 64'h100, 3, 0);

        // Read burst with rready stalls.
        do_read(Base + 64'h100, 2, 1);

        // Two back-to-back conflicts: write first, then read, then the pending write.
        for (int b = 0; b < 2; b++) begin
            wd[b] = 32'hC0DE_0000 + 32'(b);
            ws[b] = 4'hF;
        end
        s_axi_araddr  = Base + 64'h100;
        s_axi_arlen   = 8'd1;
        s_axi_arvalid = 1'b1;
        aw_phase(Base + 64'h200, 1);
        w_phase(Base + 64'h200, 1, -1);
        b_phase(1'b1, Base + 64'h208, 0);
        ar_phase(Base + 64'h100, 1);
        r_phase(Base + 64'h100, 1, 0);
        wd[0] = 32'h1234_5678;
        aw_phase(Base + 64'h208, 0);
        w_phase(Base + 64'h208, 0, -1);
        b_phase(1'b0, 64'd0, 0);
        do_read(Base + 64'h200, 2, 0);

        // Index wrap from the last word to word 0.
        wd[0] = 32'hA5A5_0001;
        wd[1] = 32'hA5A5_0002;
        ws[0] = 4'hF;
        ws[1] = 4'hF;
        do_write(Base + 64'h3FFC, 1, -1);
        do_read(Base, 0, 0);
        do_read(Base + 64'h3FFC, 1, 0);

        // Randomized traffic in a prefilled window (words 256..319).
        for (int b = 0; b < 64; b++) begin
            wd[b] = $urandom;
            ws[b] = 4'hF;
        end
        do_write(Base + 64'h400, 63, -1);
        for (int i = 0; i < 24; i++) begin
            int          len;
            logic [63:0] addr;
            len  = $urandom_range(0, 7);
            addr = Base + 64'(4 * (256 + $urandom_range(0, 56))) + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= len; b++) begin
                    wd[b] = $urandom;
                    ws[b] = 4'($urandom_range(0, 15));
                end
                do_write(addr, len, -1);
            end else begin
                do_read(addr, len, 0);
            end
        end

        // Misplaced wlast: flagged, yet all four beats are taken.
        check("perr_before", 64'(protocol_err), 64'd0);
        for (int b = 0; b < 4; b++) begin
            wd[b] = 32'h5000_0000 + 32'(b);
            ws[b] = 4'hF;
        end
        do_write(Base + 64'h500, 3, 1);
        check("perr_sticky", 64'(protocol_err), 64'd1);

        // Reset in the middle of a read burst.
        ar_phase(Base + 64'h400, 7);
        n = 0;
        while (!s_axi_rvalid && n < 10) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check("pre_rst_rvalid", 64'(s_axi_rvalid), 64'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("async_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("async_perr", 64'(protocol_err), 64'd0);
        pref_wr = 1'b1;
        perr_m  = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        check("post_rst_rvalid", 64'(s_axi_rvalid), 64'd0);

        // Memory survives reset, and the grant pointer favours write again.
        do_read(Base + 64'h500, 3, 0);
        wd[0] = 32'h0BAD_F00D;
        ws[0] = 4'hF;
        s_axi_araddr  = Base + 64'h500;
        s_axi_arlen   = 8'd0;
        s_axi_arvalid = 1'b1;
        aw_phase(Base + 64'h500, 0);
        w_phase(Base + 64'h500, 0, -1);
        b_phase(1'b0, 64'd0, 0);
        ar_phase(Base + 64'h500, 0);
        r_phase(Base + 64'h500, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
